// File: rtl/picobello_link_arbiter.sv
// rtl/picobello_link_arbiter.sv - wormhole round-robin output-link arbiter (option: PICOBELLO_LINK_ARB_OUT_REG_EN)
module picobello_link_arbiter #(
  parameter int NumInp      = 5,
  parameter int FlitWidth   = 64,
  parameter int TileX       = 0,
  parameter int TileY       = 0,
  parameter int OutDir      = 4,
  parameter int StallThresh = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumInp-1:0]                valid_i,
  output logic [NumInp-1:0]                ready_o,
  input  logic [NumInp-1:0][FlitWidth-1:0] data_i,
  input  logic [NumInp-1:0]                last_i,
  output logic                             valid_o,
  input  logic                             ready_i,
  output logic [FlitWidth-1:0]             data_o,
  output logic                             last_o,
  output logic [2:0]                       idx_o,
  output logic                             busy_o,
  output logic                             stall_o
);

  localparam int NumXMesh = 3;
  localparam int NumYMesh = 2;
  localparam int DirNorth = 0;
  localparam int DirEast  = 1;
  localparam int DirSouth = 2;
  localparam int DirWest  = 3;
  localparam int CntW     = $clog2(StallThresh + 1);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e               state_q, state_d;
  logic [2:0]           ptr_q, ptr_d, lk_q, lk_d, idx_q;
  logic [CntW-1:0]      cnt_q;
  logic [NumInp-1:0]    elig;
  logic                 grant_vld;
  logic [2:0]           grant;
  logic                 arb_valid, arb_ready, arb_last, hs;
  logic [FlitWidth-1:0] arb_data;
  int                   cand;

  function automatic logic [2:0] next_idx(input logic [2:0] i);
    return (i == 3'(NumInp - 1)) ? 3'd0 : i + 3'd1;
  endfunction

  // Static eligibility: no U-turn and no direction that leaves the mesh edge
  always_comb begin
    for (int i = 0; i < NumInp; i++) begin
      elig[i] = !((i == OutDir) ||
                  (TileX == 0            && i == DirWest)  ||
                  (TileX == NumXMesh - 1 && i == DirEast)  ||
                  (TileY == 0            && i == DirSouth) ||
                  (TileY == NumYMesh - 1 && i == DirNorth));
    end
  end

  // Grant selection: locked input, else first eligible valid input from ptr
  always_comb begin
    grant_vld = 1'b0;
    grant     = idx_q;
    cand      = 0;
    if (state_q == LOCKED) begin
      grant_vld = 1'b1;
      grant     = lk_q;
    end else begin
      for (int k = 0; k < NumInp; k++) begin
        cand = (int'(ptr_q) + k) % NumInp;
        if (!grant_vld && elig[cand] && valid_i[cand]) begin
          grant_vld = 1'b1;
          grant     = 3'(cand);
        end
      end
    end
  end

  // Arbiter-side datapath and per-input ready
  always_comb begin
    arb_valid = grant_vld && valid_i[grant];
    arb_data  = grant_vld ? data_i[grant] : '0;
    arb_last  = grant_vld && last_i[grant];
    for (int i = 0; i < NumInp; i++) begin
      ready_o[i] = grant_vld && (grant == 3'(i)) && arb_ready;
    end
  end

  assign hs      = arb_valid && arb_ready;
  assign idx_o   = grant;
  assign busy_o  = (state_q == LOCKED);
  assign stall_o = (cnt_q == CntW'(StallThresh));

  // Next-state: lock on anything but an accepted last flit, rotate ptr on packet end
  always_comb begin
    state_d = state_q;
    lk_d    = lk_q;
    ptr_d   = ptr_q;
    if (state_q == IDLE) begin
      if (arb_valid) begin
        if (hs && arb_last) begin
          ptr_d = next_idx(grant);
        end else begin
          state_d = LOCKED;
          lk_d    = grant;
        end
      end
    end else if (hs && arb_last) begin
      state_d = IDLE;
      ptr_d   = next_idx(lk_q);
    end
  end

  // State, pointer, held index and saturating stall counter
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      lk_q    <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lk_q    <= lk_d;
      idx_q   <= grant;
      if (!arb_valid || hs) begin
        cnt_q <= '0;
      end else if (cnt_q != CntW'(StallThresh)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

`ifdef PICOBELLO_LINK_ARB_OUT_REG_EN
  logic [1:0]         sp_cnt_q;
  logic               sp_wr_q, sp_rd_q, sp_push, sp_pop;
  logic [FlitWidth:0] sp_mem_q [2];

  assign arb_ready         = (sp_cnt_q != 2'd2);
  assign sp_push           = arb_valid && arb_ready;
  assign valid_o           = (sp_cnt_q != 2'd0);
  assign sp_pop            = valid_o && ready_i;
  assign {last_o, data_o}  = sp_mem_q[sp_rd_q];

  // Two-entry spill FIFO decoupling upstream ready from ready_i
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sp_cnt_q    <= '0;
      sp_wr_q     <= 1'b0;
      sp_rd_q     <= 1'b0;
      sp_mem_q[0] <= '0;
      sp_mem_q[1] <= '0;
    end else begin
      if (sp_push) begin
        sp_mem_q[sp_wr_q] <= {arb_last, arb_data};
        sp_wr_q           <= ~sp_wr_q;
      end
      if (sp_pop) begin
        sp_rd_q <= ~sp_rd_q;
      end
      sp_cnt_q <= sp_cnt_q + {1'b0, sp_push} - {1'b0, sp_pop};
    end
  end
`else
  assign arb_ready = ready_i;
  assign valid_o   = arb_valid;
  assign data_o    = arb_data;
  assign last_o    = arb_last;
`endif

endmodule

// File: tb/tb_picobello_link_arbiter.sv
// tb/tb_picobello_link_arbiter.sv - scoreboard bench for picobello_link_arbiter
module tb_picobello_link_arbiter;

  localparam int NI = 5;
  localparam int FW = 32;
  localparam int TX = 1;
  localparam int TY = 0;
  localparam int OD = 4;
  localparam int ST = 8;

  logic              clk = 1'b0;
  logic              rst_ni = 1'b0;
  logic [NI-1:0]     valid_i = '0;
  logic [NI-1:0]     ready_o;
  logic [NI-1:0][FW-1:0] data_i = '0;
  logic [NI-1:0]     last_i = '0;
  logic              valid_o;
  logic              ready_i = 1'b0;
  logic [FW-1:0]     data_o;
  logic              last_o;
  logic [2:0]        idx_o;
  logic              busy_o;
  logic              stall_o;

  picobello_link_arbiter #(
    .NumInp(NI), .FlitWidth(FW), .TileX(TX), .TileY(TY), .OutDir(OD), .StallThresh(ST)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .last_i(last_i), .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .last_o(last_o),
    .idx_o(idx_o), .busy_o(busy_o), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [FW-1:0] d; logic l; } flit_t;
  typedef struct packed { logic [FW-1:0] d; logic l; logic [2:0] idx; } exp_t;

  flit_t q [NI][$];
  logic  pres [NI];
  exp_t  exp_q [$];
  int    vectors = 0;
  int    miscompares = 0;
  int    vprob = 100;
  int    rprob = 100;

  // Reference model state: packet in progress, rotating start, stall run length
  int m_cur = -1;
  int m_ptr = 0;
  int m_stall = 0;
  int m_idx = 0;
  int hs_prev = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  function automatic bit eligible(input int c);
    return !((c == OD) || (TX == 0 && c == 3) || (TX == 2 && c == 1) ||
             (TY == 0 && c == 2) || (TY == 1 && c == 0));
  endfunction

  task automatic gen_pkt(input int i, input int len);
    flit_t f;
    for (int n = 0; n < len; n++) begin
      f.d = $urandom;
      f.l = (n == len - 1);
      q[i].push_back(f);
    end
  endtask

  task automatic model_reset();
    m_cur = -1; m_ptr = 0; m_stall = 0; m_idx = 0; hs_prev = -1;
  endtask

  // One clock cycle: retire accepted flit, drive inputs, predict and check
  task automatic step();
    int g;
    bit ev;
    logic [NI-1:0] er;
    exp_t e;
    @(posedge clk); #1;
    if (hs_prev >= 0) begin
      void'(q[hs_prev].pop_front());
      pres[hs_prev] = 1'b0;
    end
    hs_prev = -1;
    for (int i = 0; i < NI; i++) begin
      if (!pres[i] && q[i].size() > 0 && ($urandom % 100) < vprob) pres[i] = 1'b1;
      valid_i[i] = pres[i];
      data_i[i]  = pres[i] ? q[i][0].d : FW'($urandom);
      last_i[i]  = pres[i] ? q[i][0].l : 1'($urandom);
    end
    ready_i = (($urandom % 100) < rprob);
    #1;
    g = -1;
    if (m_cur >= 0) g = m_cur;
    else begin
      for (int k = 0; k < NI; k++) begin
        if (g < 0 && eligible((m_ptr + k) % NI) && valid_i[(m_ptr + k) % NI]) g = (m_ptr + k) % NI;
      end
    end
    ev = (g >= 0) && valid_i[g];
    er = (g >= 0 && ready_i) ? NI'(1 << g) : '0;
    chk("valid_o", 64'(valid_o), 64'(ev));
    chk("ready_o", 64'(ready_o), 64'(er));
    chk("idx_o", 64'(idx_o), 64'((g >= 0) ? g : m_idx));
    chk("busy_o", 64'(busy_o), 64'(m_cur >= 0));
    chk("stall_o", 64'(stall_o), 64'(m_stall >= ST));
    if (g >= 0) m_idx = g;
    if (ev && ready_i) begin
      e.d = data_i[g]; e.l = last_i[g]; e.idx = 3'(g);
      exp_q.push_back(e);
      hs_prev = g;
      if (last_i[g]) begin m_cur = -1; m_ptr = (g + 1) % NI; end
      else m_cur = g;
    end else if (ev) m_cur = g;
    m_stall = (ev && !ready_i) ? ((m_stall < ST) ? m_stall + 1 : ST) : 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_ni = 1'b0;
    for (int i = 0; i < NI; i++) begin q[i].delete(); pres[i] = 1'b0; end
    valid_i = '0; last_i = '0; data_i = '0; ready_i = 1'b0;
    @(posedge clk); #1;
    chk("rst valid_o", 64'(valid_o), 64'd0);
    chk("rst last_o", 64'(last_o), 64'd0);
    chk("rst data_o", 64'(data_o), 64'd0);
    chk("rst idx_o", 64'(idx_o), 64'd0);
    chk("rst busy_o", 64'(busy_o), 64'd0);
    chk("rst stall_o", 64'(stall_o), 64'd0);
    chk("rst ready_o", 64'(ready_o), 64'd0);
    rst_ni = 1'b1;
    model_reset();
  endtask

  // Monitor: every output handshake must match the oldest predicted flit
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_ni && valid_o && ready_i) begin
        if (exp_q.size() == 0) chk("unexpected flit", 64'(data_o), 64'hDEAD);
        else begin
          e = exp_q.pop_front();
          chk("data_o", 64'(data_o), 64'(e.d));
          chk("last_o", 64'(last_o), 64'(e.l));
          chk("flit idx_o", 64'(idx_o), 64'(e.idx));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < NI; i++) pres[i] = 1'b0;
    do_reset();

    // Only masked inputs (South, Eject) request
    gen_pkt(2, 1); gen_pkt(4, 1);
    for (int c = 0; c < 5; c++) step();
    do_reset();

    // North and East stream single-flit packets at full rate
    for (int n = 0; n < 5; n++) begin gen_pkt(0, 1); gen_pkt(1, 1); end
    for (int c = 0; c < 12; c++) step();

    // East 4-flit packet competing with North
    gen_pkt(1, 4); gen_pkt(0, 1);
    for (int c = 0; c < 8; c++) step();

    // Long stall on a West packet, then release
    gen_pkt(3, 2);
    rprob = 0;
    for (int c = 0; c < 12; c++) step();
    rprob = 100;
    for (int c = 0; c < 4; c++) step();

    // Randomized traffic on all inputs including masked ones
    vprob = 60; rprob = 70;
    gen_pkt(2, 1); gen_pkt(4, 1);
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 4; i++) if (eligible(i) && q[i].size() == 0) gen_pkt(i, $urandom_range(1, 4));
      step();
    end

    // Reset two flits into a 4-flit packet, then search restarts at North
    do_reset();
    vprob = 100; rprob = 100;
    gen_pkt(1, 4);
    step(); step();
    do_reset();
    gen_pkt(3, 1); gen_pkt(1, 1); gen_pkt(0, 1);
    for (int c = 0; c < 6; c++) step();

    @(posedge clk); #1;
    chk("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
